vote_collect_arbiter: RTL and testbench

- Sequences one classification pass into the vote buffer: clears the buffer, then collects results from N_ENG tree engines.
- Round-robin arbitrates the engines onto the buffer's single write stream (res_vld/res_val), counts accepted votes against a programmed total, and signals done.
- Sits between the tree engine array and the vote buffer (drives its buffer_rst, res_vld and res_val inputs).

---
 rtl/vote_collect_arbiter.sv | 131 +++++++++++++
 tb/tb_vote_collect_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vote_collect_arbiter.sv
// Vote collection sequencer: clears the vote buffer, then round-robin merges N_ENG engine results into it.
// Optional macro VOTE_COLLECT_ARB_TAG_EN overwrites the result MSBs with the granted engine index.
module vote_collect_arbiter #(
    parameter int N_ENG     = 4,
    parameter int RES_WIDTH = 16,
    parameter int DEPTH_BIT = 13,
    parameter int IDX_W     = $clog2(N_ENG)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [DEPTH_BIT:0]         i_expected,
    input  logic [N_ENG-1:0]           i_eng_vld,
    input  logic [N_ENG*RES_WIDTH-1:0] i_eng_val,
    output logic [N_ENG-1:0]           o_eng_rdy,
    output logic                       o_buffer_rst,
    output logic                       o_res_vld,
    output logic [RES_WIDTH-1:0]       o_res_val,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_cfg_err,
    output logic [DEPTH_BIT:0]         o_count
);

    localparam logic [DEPTH_BIT:0] CAPACITY = {1'b1, {DEPTH_BIT{1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [IDX_W-1:0]     ptr;
    logic [DEPTH_BIT:0]   count;
    logic [DEPTH_BIT:0]   count_inc;
    logic [DEPTH_BIT:0]   expected;
    logic                 cfg_err;
    logic                 start_ok;
    logic                 xfer;
    logic [N_ENG-1:0]     grant;
    logic [IDX_W-1:0]     grant_idx;
    logic [RES_WIDTH-1:0] sel_val;
    logic [RES_WIDTH-1:0] out_val;
    logic                 res_vld;
    logic [RES_WIDTH-1:0] res_val;

    // First requesting engine at or above the pointer, wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        xfer      = 1'b0;
        if (state == COLLECT) begin
            for (int i = 0; i < N_ENG; i++) begin
                if (!xfer && i_eng_vld[(int'(ptr) + i) % N_ENG]) begin
                    xfer      = 1'b1;
                    grant_idx = IDX_W'((int'(ptr) + i) % N_ENG);
                    grant[(int'(ptr) + i) % N_ENG] = 1'b1;
                end
            end
        end
    end

    assign count_inc = count + 1'b1;
    assign sel_val   = i_eng_val[int'(grant_idx) * RES_WIDTH +: RES_WIDTH];

`ifdef VOTE_COLLECT_ARB_TAG_EN
    assign out_val = {grant_idx, sel_val[RES_WIDTH-IDX_W-1:0]};
`else
    assign out_val = sel_val;
`endif

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    start_ok   = 1'b1;
                    state_next = (i_expected > CAPACITY) ? DONE : CLEAR;
                end
            end
            CLEAR:   state_next = (expected == '0) ? DONE : COLLECT;
            COLLECT: if (xfer && (count_inc == expected)) state_next = DONE;
            default: state_next = IDLE;
        endcase
        // Abort overrides everything, including a start in the same cycle.
        if (i_abort) begin
            state_next = IDLE;
            start_ok   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            count    <= '0;
            expected <= '0;
            cfg_err  <= 1'b0;
            res_vld  <= 1'b0;
            res_val  <= '0;
        end else begin
            state   <= state_next;
            res_vld <= xfer;
            if (start_ok) begin
                expected <= i_expected;
                count    <= '0;
                cfg_err  <= (i_expected > CAPACITY);
            end
            if (xfer) begin
                count   <= count_inc;
                res_val <= out_val;
                ptr     <= (grant_idx == IDX_W'(N_ENG - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign o_eng_rdy    = grant;
    assign o_buffer_rst = (state == CLEAR);
    assign o_res_vld    = res_vld;
    assign o_res_val    = res_val;
    assign o_busy       = (state == CLEAR) || (state == COLLECT);
    assign o_done       = (state == DONE);
    assign o_cfg_err    = cfg_err;
    assign o_count      = count;

endmodule

// File: tb/tb_vote_collect_arbiter.sv
// Randomized self-checking bench for vote_collect_arbiter against a per-cycle behavioural model.
module tb_vote_collect_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int DB  = 13;
    localparam int CAP = 1 << DB;

    localparam int P_IDLE    = 0;
    localparam int P_CLEAR   = 1;
    localparam int P_COLLECT = 2;
    localparam int P_DONE    = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_start;
    logic           i_abort;
    logic [DB:0]    i_expected;
    logic [N-1:0]   i_eng_vld;
    logic [N*W-1:0] i_eng_val;
    logic [N-1:0]   o_eng_rdy;
    logic           o_buffer_rst;
    logic           o_res_vld;
    logic [W-1:0]   o_res_val;
    logic           o_busy;
    logic           o_done;
    logic           o_cfg_err;
    logic [DB:0]    o_count;

    int checks = 0;
    int errors = 0;

    int          m_phase, m_ptr, m_cnt, m_exp;
    bit          m_err, m_rv;
    logic [W-1:0] m_rval;
    int          waits [N];
    int          clr_pulses, rv_pulses, rdy_seen;

    vote_collect_arbiter #(.N_ENG(N), .RES_WIDTH(W), .DEPTH_BIT(DB)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_expected(i_expected), .i_eng_vld(i_eng_vld), .i_eng_val(i_eng_val),
        .o_eng_rdy(o_eng_rdy), .o_buffer_rst(o_buffer_rst), .o_res_vld(o_res_vld),
        .o_res_val(o_res_val), .o_busy(o_busy), .o_done(o_done),
        .o_cfg_err(o_cfg_err), .o_count(o_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_ptr = 0; m_cnt = 0; m_exp = 0;
        m_err = 0; m_rv = 0; m_rval = '0;
        for (int e = 0; e < N; e++) waits[e] = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rdy"},  64'(o_eng_rdy), 64'd0);
        check_eq({tag, "_brst"}, 64'(o_buffer_rst), 64'd0);
        check_eq({tag, "_rv"},   64'(o_res_vld), 64'd0);
        check_eq({tag, "_rval"}, 64'(o_res_val), 64'd0);
        check_eq({tag, "_busy"}, 64'(o_busy), 64'd0);
        check_eq({tag, "_done"}, 64'(o_done), 64'd0);
        check_eq({tag, "_err"},  64'(o_cfg_err), 64'd0);
        check_eq({tag, "_cnt"},  64'(o_count), 64'd0);
    endtask

    // One clock: drive at negedge, compare shortly after, then advance the model.
    task automatic step(input bit start, input bit abort, input int exp_in, input logic [N-1:0] vld);
        int k;
        logic [N-1:0] rdy;
        logic [W-1:0] d;
        @(negedge clk);
        i_start = start; i_abort = abort; i_expected = (DB+1)'(exp_in); i_eng_vld = vld;
        for (int e = 0; e < N; e++) i_eng_val[e*W +: W] = W'($urandom);
        #1;
        k = -1;
        if (m_phase == P_COLLECT)
            for (int i = 0; i < N; i++)
                if (k < 0 && vld[(m_ptr + i) % N]) k = (m_ptr + i) % N;
        rdy = (k >= 0) ? N'(1 << k) : '0;
        check_eq("rdy",  64'(o_eng_rdy), 64'(rdy));
        check_eq("brst", 64'(o_buffer_rst), 64'(m_phase == P_CLEAR));
        check_eq("busy", 64'(o_busy), 64'(m_phase == P_CLEAR || m_phase == P_COLLECT));
        check_eq("done", 64'(o_done), 64'(m_phase == P_DONE));
        check_eq("err",  64'(o_cfg_err), 64'(m_err));
        check_eq("cnt",  64'(o_count), 64'(m_cnt));
        check_eq("rv",   64'(o_res_vld), 64'(m_rv));
        check_eq("rval", 64'(o_res_val), 64'(m_rval));
        clr_pulses += int'(o_buffer_rst);
        rv_pulses  += int'(o_res_vld);
        rdy_seen   += int'(o_eng_rdy != '0);
        if (k >= 0) begin
            check_eq("starve", 64'(waits[k] <= N - 1), 64'd1);
            for (int e = 0; e < N; e++) waits[e] = (e != k && vld[e]) ? waits[e] + 1 : 0;
            d = i_eng_val[k*W +: W];
`ifdef VOTE_COLLECT_ARB_TAG_EN
            d[W-1 -: 2] = 2'(k);
`endif
            m_rval = d; m_rv = 1; m_ptr = (k + 1) % N; m_cnt++;
        end else begin
            m_rv = 0;
        end
        if (abort) m_phase = P_IDLE;
        else if (m_phase == P_IDLE || m_phase == P_DONE) begin
            if (start) begin
                m_exp = exp_in; m_cnt = 0; m_err = (exp_in > CAP);
                m_phase = m_err ? P_DONE : P_CLEAR;
            end
        end else if (m_phase == P_CLEAR) m_phase = (m_exp == 0) ? P_DONE : P_COLLECT;
        else if (k >= 0 && m_cnt == m_exp) m_phase = P_DONE;
    endtask

    task automatic idle(input int n, input logic [N-1:0] vld);
        for (int i = 0; i < n; i++) step(0, 0, 0, vld);
    endtask

    initial begin
        rst_n = 1'b0; i_start = 0; i_abort = 0; i_expected = '0; i_eng_vld = '0; i_eng_val = '0;
        model_reset();
        #2;
        check_all_zero("reset");
        #10 rst_n = 1'b1;

        // All engines requesting, 8 votes.
        clr_pulses = 0; rv_pulses = 0;
        step(1, 0, 8, 4'hF);
        idle(12, 4'hF);
        check_eq("t1_clr_pulses", 64'(clr_pulses), 64'd1);
        check_eq("t1_rv_pulses", 64'(rv_pulses), 64'd8);
        check_eq("t1_count", 64'(o_count), 64'd8);

        // Only engine 2, pointer back at 0.
        rv_pulses = 0;
        step(1, 0, 3, 4'b0100);
        idle(8, 4'b0100);
        check_eq("t2_rv_pulses", 64'(rv_pulses), 64'd3);

        // Zero votes: clear then done, no grants.
        clr_pulses = 0; rv_pulses = 0; rdy_seen = 0;
        step(1, 0, 0, 4'hF);
        idle(5, 4'hF);
        check_eq("t3_clr", 64'(clr_pulses), 64'd1);
        check_eq("t3_rdy", 64'(rdy_seen), 64'd0);
        check_eq("t3_rv", 64'(rv_pulses), 64'd0);

        // Over capacity, then a legal restart.
        clr_pulses = 0;
        step(1, 0, CAP + 1, 4'hF);
        idle(3, 4'hF);
        check_eq("t4_clr", 64'(clr_pulses), 64'd0);
        check_eq("t4_err", 64'(o_cfg_err), 64'd1);
        step(1, 0, 4, 4'hA);
        idle(8, 4'hA);
        check_eq("t4_err_clr", 64'(o_cfg_err), 64'd0);

        // Abort after 3 of 10.
        step(1, 0, 10, 4'h0);
        step(0, 0, 0, 4'h0);
        idle(3, 4'hF);
        step(0, 1, 0, 4'h0);
        idle(1, 4'hF);
        check_eq("t5_cnt", 64'(o_count), 64'd3);
        check_eq("t5_done", 64'(o_done), 64'd0);
        step(1, 0, 2, 4'h0);
        idle(1, 4'h0);
        check_eq("t5_restart_cnt", 64'(o_count), 64'd0);
        idle(6, 4'h3);

        // Full capacity, exact fill.
        step(1, 0, CAP, 4'hF);
        idle(CAP + 4, 4'hF);
        check_eq("t6_full", 64'(o_count), 64'(CAP));

        // Mid-pass asynchronous reset.
        step(1, 0, 20, 4'hF);
        idle(4, 4'hF);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        #2 rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            int ex;
            ex = ($urandom_range(0, 19) == 0) ? CAP + int'($urandom_range(1, 4)) : int'($urandom_range(0, 20));
            step($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0, ex, N'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
